wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4: consecutive blocked cycles before the arbiter forces a pipeline bubble (legal range 1-7).
REQ-002 SHALL have port Clk  input  1  clock, all state updates on the rising edge.
REQ-003 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pipe_regWrite  input  1  writeback request from the MEM/WB stage.
REQ-005 SHALL have port pipe_wrAddr  input  5  destination register of the pipeline writeback.
REQ-006 SHALL have port pipe_wrData  input  32  writeback data, already muxed between memory data and ALU result.
REQ-007 SHALL have port mdu_valid  input  1  multiply/divide unit result valid.
REQ-008 SHALL have port mdu_wrAddr  input  5  destination register of the MDU result.
REQ-009 SHALL have port mdu_wrData  input  32  MDU result data.
REQ-010 SHALL have port mdu_ready  output  1  hold buffer empty, so the MDU result is accepted this cycle.
REQ-011 SHALL have port rf_regWrite  output  1  register-file write enable, registered.
REQ-012 SHALL have port rf_wrAddr  output  5  register-file write address, registered.
REQ-013 SHALL have port rf_wrData  output  32  register-file write data, registered.
REQ-014 SHALL have port stall_pipe  output  1  request to the hazard unit to insert one bubble into MEM/WB, registered.
REQ-015 SHALL have ports pending_valid (output, 1) and pending_addr (output, 5), giving the buffered MDU destination so the hazard unit can stall readers.

Function
REQ-016 SHALL give a pipeline write (pipe_regWrite=1 with pipe_wrAddr!=0) unconditional priority; its value appears on rf_* one cycle later.
REQ-017 SHALL treat a pipeline request with pipe_wrAddr=0 as idle: no rf write, and the port counts as free for draining.
REQ-018 SHALL drive mdu_ready=1 only in state EMPTY; a transfer occurs when mdu_valid and mdu_ready are both 1 on a clock edge; the captured result moves to state HELD.
REQ-019 SHALL accept an MDU result with mdu_wrAddr=0 and drop it, remaining in EMPTY.
REQ-020 SHALL drain the HELD entry to rf_* on the next edge of any cycle where the pipeline port is idle, then return to EMPTY; minimum MDU-to-register-file latency is 2 cycles.
REQ-021 SHALL, in HELD, increment a 3-bit wait counter on each cycle the pipeline holds the port, saturating at 7 and clearing on drain or discard.
REQ-022 SHALL enter state STARVED and assert stall_pipe when the wait counter reaches MAX_WAIT; stall_pipe stays high until the entry drains, and is low in the cycle after the drain.
REQ-023 SHALL discard the HELD entry without writing it when a pipeline write targets pending_addr; that pipeline instruction is the younger writer. The state returns to EMPTY and stall_pipe deasserts on the next edge.
REQ-024 SHALL drive rf_regWrite=0 in any cycle with neither a pipeline write nor a drain; rf_wrAddr and rf_wrData hold their previous values.
REQ-025 SHALL drive pending_valid=1 exactly in HELD and STARVED, with pending_addr equal to the buffered address.
REQ-026 SHALL never issue two register-file writes in one cycle and never lose an accepted MDU result with a nonzero address, except through the REQ-023 discard.

Reset
REQ-027 SHALL, while Rst=1, immediately force state EMPTY, wait counter 0, rf_regWrite=0, rf_wrAddr=0, rf_wrData=0, stall_pipe=0 and pending_valid=0; pending_addr follows the cleared buffer and reads 0.
REQ-028 SHALL drop a HELD entry on reset mid-operation; mdu_ready is 1 on the first cycle after Rst deasserts.

Structure
REQ-029 SHALL take the state encoding (EMPTY, HELD, STARVED), the register-address width (5), the data width (32) and the MAX_WAIT default from the shared pipeline package.
REQ-030 SHALL place the one-entry buffer, together with its address, data and valid flag, in sub-module wb_hold_buffer; the arbitration FSM and the wait counter stay in the top module.

Verification
REQ-031 SHALL check: pipe write addr 8, data 0x0000_00AA, with MDU idle -> rf_regWrite=1, addr 8, data 0xAA one cycle later; mdu_ready stays 1.
REQ-032 SHALL check: MDU addr 9, data 0x1234_5678, with the pipeline idle -> accepted, pending_valid=1, addr 9; rf write of addr 9 two cycles after acceptance; mdu_ready back to 1.
REQ-033 SHALL check: MDU addr 9 held while the pipeline writes addrs 1-6 back-to-back, MAX_WAIT=4 -> stall_pipe rises after the 4th blocked cycle; after the bench inserts one bubble, addr 9 is written and stall_pipe falls.
REQ-034 SHALL check: MDU addr 12 held, then a pipe write to addr 12 with data 0x55 -> only 0x55 is written to addr 12; pending_valid=0 on the next cycle.
REQ-035 SHALL check: Rst pulsed while in STARVED with addr 9 pending -> all outputs 0 at once, no write of addr 9 ever occurs, and mdu_ready=1 after release.
REQ-036 SHALL check: pipe write to addr 0, and an MDU result to addr 0 -> no rf_regWrite pulse in either case, and the FSM stays in EMPTY.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared pipeline definitions for the writeback-port arbiter: widths,
// the hold-buffer state encoding and the wait-counter helper.
package wb_port_arbiter_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int DATA_W           = 32;
  localparam int WAIT_W           = 3;
  localparam int MAX_WAIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HELD    = 2'd1,
    ST_STARVED = 2'd2
  } wb_state_e;

  // Saturating increment so a long pipeline burst cannot wrap the counter
  // back below the starvation threshold.
  function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] cnt);
    logic [WAIT_W-1:0] res;
    if (cnt == 3'd7) begin
      res = cnt;
    end else begin
      res = cnt + 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_hold.sv
// One-entry holding register for an MDU result waiting for a free
// register-file write port. Clearing also zeroes the address so the
// pending_addr seen by the hazard unit is 0 whenever nothing is held.
module wb_hold_buffer
  import wb_port_arbiter_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_data,
  output logic                  o_valid,
  output logic [REG_ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0]     o_data
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]     r_data;

  // Capture a new entry, release it on drain/discard, otherwise hold.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_valid <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= 32'd0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= 32'd0;
    end else begin
      r_valid <= r_valid;
      r_addr  <= r_addr;
      r_data  <= r_data;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the MEM/WB
// pipeline (always wins) and the multiply/divide unit, whose result waits
// in a one-entry buffer. A buffered result that is starved for MAX_WAIT
// cycles asks the hazard unit for a bubble; a younger pipeline write to the
// same register makes the buffered result obsolete and it is dropped.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  pipe_regWrite,
  input  logic [REG_ADDR_W-1:0] pipe_wrAddr,
  input  logic [DATA_W-1:0]     pipe_wrData,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_wrAddr,
  input  logic [DATA_W-1:0]     mdu_wrData,
  output logic                  mdu_ready,
  output logic                  rf_regWrite,
  output logic [REG_ADDR_W-1:0] rf_wrAddr,
  output logic [DATA_W-1:0]     rf_wrData,
  output logic                  stall_pipe,
  output logic                  pending_valid,
  output logic [REG_ADDR_W-1:0] pending_addr
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  wb_state_e             r_state;
  wb_state_e             w_state_nxt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [WAIT_W-1:0]     w_wait_nxt;

  logic                  w_pipe_wr;
  logic                  w_buf_load;
  logic                  w_drain;
  logic                  w_discard;
  logic                  w_buf_valid;
  logic [REG_ADDR_W-1:0] w_buf_addr;
  logic [DATA_W-1:0]     w_buf_data;

  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0]     r_rf_data;
  logic                  r_stall;

  // A write to r0 is architecturally a no-op, so it does not occupy the port.
  assign w_pipe_wr = pipe_regWrite && (pipe_wrAddr != 5'd0);

  wb_hold_buffer u_hold (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_load  (w_buf_load),
    .i_clear (w_drain || w_discard),
    .i_addr  (mdu_wrAddr),
    .i_data  (mdu_wrData),
    .o_valid (w_buf_valid),
    .o_addr  (w_buf_addr),
    .o_data  (w_buf_data)
  );

  // Next-state, wait-counter and buffer-control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_buf_load  = 1'b0;
    w_drain     = 1'b0;
    w_discard   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_wait_nxt = 3'd0;
        if (mdu_valid && (mdu_wrAddr != 5'd0)) begin
          w_buf_load  = 1'b1;
          w_state_nxt = ST_HELD;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_HELD, ST_STARVED: begin
        if (w_pipe_wr && (pipe_wrAddr == w_buf_addr)) begin
          w_discard   = 1'b1;
          w_wait_nxt  = 3'd0;
          w_state_nxt = ST_EMPTY;
        end else if (!w_pipe_wr) begin
          w_drain     = 1'b1;
          w_wait_nxt  = 3'd0;
          w_state_nxt = ST_EMPTY;
        end else begin
          w_wait_nxt = wait_sat_inc(r_wait_cnt);
          if (w_wait_nxt >= WAIT_LIMIT) begin
            w_state_nxt = ST_STARVED;
          end else begin
            w_state_nxt = ST_HELD;
          end
        end
      end
      default: begin
        w_wait_nxt  = 3'd0;
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= ST_EMPTY;
      r_wait_cnt <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Registered register-file port and bubble request; address/data hold when idle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_rf_we   <= 1'b0;
      r_rf_addr <= 5'd0;
      r_rf_data <= 32'd0;
      r_stall   <= 1'b0;
    end else begin
      r_stall <= (w_state_nxt == ST_STARVED);
      if (w_pipe_wr) begin
        r_rf_we   <= 1'b1;
        r_rf_addr <= pipe_wrAddr;
        r_rf_data <= pipe_wrData;
      end else if (w_drain) begin
        r_rf_we   <= 1'b1;
        r_rf_addr <= w_buf_addr;
        r_rf_data <= w_buf_data;
      end else begin
        r_rf_we   <= 1'b0;
        r_rf_addr <= r_rf_addr;
        r_rf_data <= r_rf_data;
      end
    end
  end

  assign mdu_ready     = (r_state == ST_EMPTY);
  assign rf_regWrite   = r_rf_we;
  assign rf_wrAddr     = r_rf_addr;
  assign rf_wrData     = r_rf_data;
  assign stall_pipe    = r_stall;
  assign pending_valid = w_buf_valid;
  assign pending_addr  = w_buf_addr;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, a
// hand-written reset-in-STARVED sequence and randomized traffic against a
// behavioural model of the writeback rules.
module tb_wb_port_arbiter;

  localparam int MAXW = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        pipe_regWrite;
  logic [4:0]  pipe_wrAddr;
  logic [31:0] pipe_wrData;
  logic        mdu_valid;
  logic [4:0]  mdu_wrAddr;
  logic [31:0] mdu_wrData;
  logic        mdu_ready;
  logic        rf_regWrite;
  logic [4:0]  rf_wrAddr;
  logic [31:0] rf_wrData;
  logic        stall_pipe;
  logic        pending_valid;
  logic [4:0]  pending_addr;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.MAX_WAIT(MAXW)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .pipe_regWrite (pipe_regWrite),
    .pipe_wrAddr   (pipe_wrAddr),
    .pipe_wrData   (pipe_wrData),
    .mdu_valid     (mdu_valid),
    .mdu_wrAddr    (mdu_wrAddr),
    .mdu_wrData    (mdu_wrData),
    .mdu_ready     (mdu_ready),
    .rf_regWrite   (rf_regWrite),
    .rf_wrAddr     (rf_wrAddr),
    .rf_wrData     (rf_wrData),
    .stall_pipe    (stall_pipe),
    .pending_valid (pending_valid),
    .pending_addr  (pending_addr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        erdy;
    logic        epv;
    logic [4:0]  epa;
    logic        estall;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  // Behavioural model: one optional buffered result plus the count of
  // consecutive cycles it has been denied the port.
  bit          m_held;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_blocked;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    pipe_regWrite = pwe;
    pipe_wrAddr   = pa;
    pipe_wrData   = pd;
    mdu_valid     = mv;
    mdu_wrAddr    = ma;
    mdu_wrData    = md;
  endtask

  task automatic model_step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                            input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bit port_busy;
    port_busy = pwe && (pa != 5'd0);
    m_we = 1'b0;
    if (port_busy) begin
      m_we = 1'b1; m_wa = pa; m_wd = pd;
    end
    if (m_held) begin
      if (port_busy && pa == m_addr) begin
        m_held = 0; m_blocked = 0;
      end else if (!port_busy) begin
        m_we = 1'b1; m_wa = m_addr; m_wd = m_data;
        m_held = 0; m_blocked = 0;
      end else begin
        m_blocked = (m_blocked < 7) ? m_blocked + 1 : 7;
      end
    end else if (mv && ma != 5'd0) begin
      m_held = 1; m_addr = ma; m_data = md; m_blocked = 0;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd8,  32'hAA,       1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  32'hAA,       1'b1, 1'b0, 5'd0,  1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd8,  32'hAA,       1'b1, 1'b0, 5'd0,  1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h12345678, 1'b0, 5'd8,  32'hAA,       1'b0, 1'b1, 5'd9,  1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h12345678, 1'b1, 1'b0, 5'd0,  1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  32'h12345678, 1'b1, 1'b0, 5'd0,  1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h99999999, 1'b0, 5'd9,  32'h12345678, 1'b0, 1'b1, 5'd9,  1'b0};
    vecs[6]  = '{1'b1, 5'd1,  32'h101,      1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  32'h101,      1'b0, 1'b1, 5'd9,  1'b0};
    vecs[7]  = '{1'b1, 5'd2,  32'h102,      1'b1, 5'd20, 32'hEEEE,     1'b1, 5'd2,  32'h102,      1'b0, 1'b1, 5'd9,  1'b0};
    vecs[8]  = '{1'b1, 5'd3,  32'h103,      1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h103,      1'b0, 1'b1, 5'd9,  1'b0};
    vecs[9]  = '{1'b1, 5'd4,  32'h104,      1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h104,      1'b0, 1'b1, 5'd9,  1'b1};
    vecs[10] = '{1'b1, 5'd5,  32'h105,      1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h105,      1'b0, 1'b1, 5'd9,  1'b1};
    vecs[11] = '{1'b1, 5'd6,  32'h106,      1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'h106,      1'b0, 1'b1, 5'd9,  1'b1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h99999999, 1'b1, 1'b0, 5'd0,  1'b0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hCCCC,     1'b0, 5'd9,  32'h99999999, 1'b0, 1'b1, 5'd12, 1'b0};
    vecs[14] = '{1'b1, 5'd12, 32'h55,       1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h55,       1'b1, 1'b0, 5'd0,  1'b0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd12, 32'h55,       1'b1, 1'b0, 5'd0,  1'b0};
    vecs[16] = '{1'b1, 5'd0,  32'hDEAD,     1'b0, 5'd0,  32'h0,        1'b0, 5'd12, 32'h55,       1'b1, 1'b0, 5'd0,  1'b0};
    vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hBEEF,     1'b0, 5'd12, 32'h55,       1'b1, 1'b0, 5'd0,  1'b0};
    vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd12, 32'h55,       1'b1, 1'b0, 5'd0,  1'b0};

    // Reset state.
    Rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #3;
    chk("rst_rf_we",    rf_regWrite,   1'b0);
    chk("rst_rf_addr",  rf_wrAddr,     5'd0);
    chk("rst_rf_data",  rf_wrData,     32'd0);
    chk("rst_stall",    stall_pipe,    1'b0);
    chk("rst_pv",       pending_valid, 1'b0);
    chk("rst_pa",       pending_addr,  5'd0);
    chk("rst_ready",    mdu_ready,     1'b1);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].mv, vecs[i].ma, vecs[i].md);
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d_rf_we", i),   rf_regWrite, vecs[i].ewe);
      chk($sformatf("vec%0d_rf_addr", i), rf_wrAddr,   vecs[i].ea);
      chk($sformatf("vec%0d_rf_data", i), rf_wrData,   vecs[i].ed);
      chk($sformatf("vec%0d_ready", i),   mdu_ready,   vecs[i].erdy);
      chk($sformatf("vec%0d_pv", i),      pending_valid, vecs[i].epv);
      if (vecs[i].epv) begin
        chk($sformatf("vec%0d_pa", i),    pending_addr, vecs[i].epa);
      end
      chk($sformatf("vec%0d_stall", i),   stall_pipe,  vecs[i].estall);
    end

    // Reset pulsed while STARVED with addr 9 pending.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9090);
    @(posedge Clk); #1;
    chk("sr_pv", pending_valid, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'(k), 32'h200 + 32'(k), 1'b0, 5'd0, 32'd0);
      @(posedge Clk); #1;
    end
    chk("sr_stall_up", stall_pipe, 1'b1);
    drive(1'b1, 5'd5, 32'h205, 1'b0, 5'd0, 32'd0);
    #2;
    Rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("sr_rf_we",   rf_regWrite,   1'b0);
    chk("sr_rf_addr", rf_wrAddr,     5'd0);
    chk("sr_rf_data", rf_wrData,     32'd0);
    chk("sr_stall",   stall_pipe,    1'b0);
    chk("sr_pv0",     pending_valid, 1'b0);
    chk("sr_pa0",     pending_addr,  5'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("sr_ready", mdu_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk); #1;
      chk("sr_no_write", rf_regWrite, 1'b0);
      chk("sr_no_addr9", rf_wrAddr,   5'd0);
    end

    // Randomized traffic against the model, starting from the reset state.
    m_held = 0; m_addr = 5'd0; m_data = 32'd0; m_blocked = 0;
    m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
    for (int c = 0; c < 600; c++) begin
      logic        pwe, mv;
      logic [4:0]  pa, ma;
      logic [31:0] pd, md;
      pwe = ($urandom_range(0, 9) < 7);
      pa  = 5'($urandom_range(0, 7));
      pd  = $urandom;
      mv  = ($urandom_range(0, 9) < 4);
      ma  = 5'($urandom_range(0, 7));
      md  = $urandom;
      model_step(pwe, pa, pd, mv, ma, md);
      drive(pwe, pa, pd, mv, ma, md);
      @(posedge Clk); #1;
      chk("rnd_rf_we",   rf_regWrite,   m_we);
      chk("rnd_rf_addr", rf_wrAddr,     m_wa);
      chk("rnd_rf_data", rf_wrData,     m_wd);
      chk("rnd_ready",   mdu_ready,     !m_held);
      chk("rnd_pv",      pending_valid, m_held);
      if (m_held) begin
        chk("rnd_pa", pending_addr, m_addr);
      end
      chk("rnd_stall", stall_pipe, (m_held && m_blocked >= MAXW));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
